// File: rtl/mac_pkg.sv
// Shared definitions for the MAC receive frame reader: pointer-word layout,
// reader FSM states, frame classification and the skid-buffer beat format.
package mac_pkg;

    localparam int LEN_MSB    = 12;
    localparam int LENERR_BIT = 14;
    localparam int CRCERR_BIT = 15;
    localparam int MAX_LEN    = 1518;
    localparam int BEAT_W     = 10;

    typedef enum logic [2:0] {
        IDLE,
        PTR_RD,
        PTR_CAP,
        FWD,
        DROP,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        K_GOOD,
        K_CRC,
        K_LEN
    } kind_e;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] data;
    } beat_t;

endpackage

// File: rtl/mac_skid_buf.sv
// Two-entry output FIFO between the data-FIFO read path and the rx stream.
// The head entry is held stable until popped; the output reads 0 when empty.
module mac_skid_buf #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         do_pop;

    assign valid_o = (cnt_q != 2'd0);
    assign do_pop  = pop_i & valid_o;
    assign count_o = cnt_q;
    assign dout_o  = valid_o ? mem_q[rd_q] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/mac_r_frame_rd.sv
// Receive frame reader: pops a pointer word, then forwards or drops the frame.
// Define MAC_R_FRAME_RD_STATS_EN to build the good/CRC/length frame counters.
module mac_r_frame_rd #(
    parameter int LEN_W   = 13,
    parameter int MAX_LEN = mac_pkg::MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ptr_fifo_rd,
    input  logic [15:0] ptr_fifo_dout,
    input  logic        ptr_fifo_empty,
    output logic        data_fifo_rd,
    input  logic [7:0]  data_fifo_dout,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    input  logic        rx_ready,
    output logic [15:0] frame_cnt,
    output logic [15:0] crc_err_cnt,
    output logic [15:0] len_err_cnt
);

    import mac_pkg::*;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             infl_q;
    logic             tag_sof_q;
    logic             tag_eof_q;

    logic [LEN_W-1:0] ptr_len;
    logic             crc_bit;
    logic             lerr_bit;
    logic             bad;
    logic             unused_ptr;

    beat_t            push_beat;
    beat_t            out_beat;
    logic [1:0]       occ;
    logic             sk_pop;
    logic [2:0]       lvl;
    logic             can_rd;

    assign ptr_len    = LEN_W'(ptr_fifo_dout[LEN_MSB:0]);
    assign crc_bit    = ptr_fifo_dout[CRCERR_BIT];
    assign lerr_bit   = ptr_fifo_dout[LENERR_BIT];
    assign unused_ptr = ptr_fifo_dout[13];
    assign bad        = crc_bit | lerr_bit | (ptr_len == '0)
                      | (32'(ptr_len) > 32'(MAX_LEN));

    // Slots committed after this edge: held + in flight - leaving now.
    assign sk_pop = rx_valid & rx_ready;
    assign lvl    = {1'b0, occ} + {2'b0, infl_q} - {2'b0, sk_pop};
    assign can_rd = (lvl < 3'd2);

    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        len_d        = len_q;
        ptr_fifo_rd  = 1'b0;
        data_fifo_rd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!ptr_fifo_empty) state_d = PTR_RD;
            end
            PTR_RD: begin
                ptr_fifo_rd = 1'b1;
                state_d     = PTR_CAP;
            end
            PTR_CAP: begin
                rd_cnt_d = ptr_len;
                len_d    = ptr_len;
                state_d  = bad ? DROP : FWD;
            end
            FWD: begin
                if (rd_cnt_q != '0) begin
                    if (can_rd) begin
                        data_fifo_rd = 1'b1;
                        rd_cnt_d     = rd_cnt_q - LEN_W'(1);
                    end
                end else if (!infl_q && !rx_valid) begin
                    state_d = DONE;
                end
            end
            DROP: begin
                if (rd_cnt_q != '0) begin
                    data_fifo_rd = 1'b1;
                    rd_cnt_d     = rd_cnt_q - LEN_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            len_q     <= '0;
            infl_q    <= 1'b0;
            tag_sof_q <= 1'b0;
            tag_eof_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            len_q     <= len_d;
            infl_q    <= data_fifo_rd && (state_q == FWD);
            tag_sof_q <= (rd_cnt_q == len_q);
            tag_eof_q <= (rd_cnt_q == LEN_W'(1));
        end
    end

    assign push_beat = '{sof: tag_sof_q, eof: tag_eof_q, data: data_fifo_dout};

    mac_skid_buf #(
        .W (BEAT_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (infl_q),
        .din_i   (push_beat),
        .pop_i   (rx_ready),
        .dout_o  (out_beat),
        .valid_o (rx_valid),
        .count_o (occ)
    );

    assign rx_data = out_beat.data;
    assign rx_sof  = out_beat.sof;
    assign rx_eof  = out_beat.eof;

`ifdef MAC_R_FRAME_RD_STATS_EN
    kind_e       kind_q;
    logic [15:0] good_q;
    logic [15:0] crc_q;
    logic [15:0] lenerr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q   <= K_GOOD;
            good_q   <= '0;
            crc_q    <= '0;
            lenerr_q <= '0;
        end else begin
            if (state_q == PTR_CAP) begin
                kind_q <= crc_bit ? K_CRC : (bad ? K_LEN : K_GOOD);
            end
            if (state_q == DONE) begin
                unique case (kind_q)
                    K_GOOD:  if (good_q != 16'hFFFF) good_q <= good_q + 16'd1;
                    K_CRC:   if (crc_q != 16'hFFFF) crc_q <= crc_q + 16'd1;
                    K_LEN:   if (lenerr_q != 16'hFFFF) lenerr_q <= lenerr_q + 16'd1;
                    default: ;
                endcase
            end
        end
    end

    assign frame_cnt   = good_q;
    assign crc_err_cnt = crc_q;
    assign len_err_cnt = lenerr_q;
`else
    assign frame_cnt   = 16'd0;
    assign crc_err_cnt = 16'd0;
    assign len_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mac_r_frame_rd.sv
// Directed bench for mac_r_frame_rd with behavioural 1-cycle-latency FIFOs.
// Counter expectations follow MAC_R_FRAME_RD_STATS_EN.
module tb_mac_r_frame_rd;

`ifdef MAC_R_FRAME_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_dout = 16'd0;
    logic        ptr_fifo_empty = 1'b1;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_dout = 8'd0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_ready = 1'b1;
    logic [15:0] frame_cnt;
    logic [15:0] crc_err_cnt;
    logic [15:0] len_err_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [15:0] ptr_q [$];
    logic [7:0]  dat_q [$];
    logic [9:0]  beats [$];
    int          beat_cyc [$];
    logic        pend_p = 1'b0;
    logic        pend_d = 1'b0;
    int          underflow = 0;
    int          data_pops = 0;
    int          ptr_pops = 0;
    int          occ_err = 0;
    int          stall_err = 0;
    bit          fwd_chk = 1'b0;
    bit          stall_prev = 1'b0;
    logic [9:0]  stall_beat = 10'd0;
    logic        empty_prev = 1'b1;
    int          empty_fall = -1;
    int          first_valid = -1;
    int          exp_good = 0;
    int          exp_crc = 0;
    int          exp_len = 0;

    mac_r_frame_rd dut (
        .clk            (clk),
        .rst            (rst),
        .ptr_fifo_rd    (ptr_fifo_rd),
        .ptr_fifo_dout  (ptr_fifo_dout),
        .ptr_fifo_empty (ptr_fifo_empty),
        .data_fifo_rd   (data_fifo_rd),
        .data_fifo_dout (data_fifo_dout),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_sof         (rx_sof),
        .rx_eof         (rx_eof),
        .rx_ready       (rx_ready),
        .frame_cnt      (frame_cnt),
        .crc_err_cnt    (crc_err_cnt),
        .len_err_cnt    (len_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // FIFO models: pops requested before the edge appear on dout after it.
    always @(posedge clk) begin
        if (rst) begin
            ptr_q.delete();
            dat_q.delete();
            ptr_fifo_dout  <= 16'd0;
            data_fifo_dout <= 8'd0;
            ptr_fifo_empty <= 1'b1;
        end else begin
            if (pend_p) begin
                if (ptr_q.size() == 0) underflow++;
                else ptr_fifo_dout <= ptr_q.pop_front();
            end
            if (pend_d) begin
                if (dat_q.size() == 0) underflow++;
                else data_fifo_dout <= dat_q.pop_front();
            end
            ptr_fifo_empty <= (ptr_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        pend_p = ptr_fifo_rd && !rst;
        pend_d = data_fifo_rd && !rst;
        if (!rst) begin
            if (data_fifo_rd) begin
                if (fwd_chk && (data_pops + 1 - beats.size()
                    - ((rx_valid && rx_ready) ? 1 : 0)) > 2) occ_err++;
                data_pops++;
            end
            if (ptr_fifo_rd) ptr_pops++;
            if (stall_prev && (!rx_valid || {rx_sof, rx_eof, rx_data} !== stall_beat))
                stall_err++;
            stall_prev = rx_valid && !rx_ready;
            stall_beat = {rx_sof, rx_eof, rx_data};
            if (empty_prev && !ptr_fifo_empty && empty_fall < 0) empty_fall = cyc;
            if (rx_valid && first_valid < 0) first_valid = cyc;
            if (rx_valid && rx_ready) begin
                beats.push_back({rx_sof, rx_eof, rx_data});
                beat_cyc.push_back(cyc);
            end
        end else begin
            stall_prev = 1'b0;
        end
        empty_prev = ptr_fifo_empty;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] p, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) dat_q.push_back(base + 8'(i));
        ptr_q.push_back(p);
    endtask

    task automatic clear_obs();
        beats.delete();
        beat_cyc.delete();
        data_pops = 0;
        ptr_pops = 0;
        empty_fall = -1;
        first_valid = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_chk++;
        if ({rx_valid, rx_sof, rx_eof, rx_data, ptr_fifo_rd, data_fifo_rd} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rx_valid, rx_sof, rx_eof, rx_data, ptr_fifo_rd, data_fifo_rd});
        end
        n_chk++;
        if ({frame_cnt, crc_err_cnt, len_err_cnt} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h want 0",
                     {frame_cnt, crc_err_cnt, len_err_cnt});
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_good_frame();
        logic [9:0] e;
        int lat;
        clear_obs();
        push_frame(16'h0040, 64, 8'h00);
        tick(120);
        exp_good++;
        n_chk++;
        if (beats.size() != 64) begin
            n_fail++;
            $display("FAIL good_count: got %0d beats want 64", beats.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                e = {i == 0, i == 63, 8'(i)};
                n_chk++;
                if (beats[i] !== e) begin
                    n_fail++;
                    $display("FAIL good_beat[%0d]: got %h want %h", i, beats[i], e);
                end
            end
            n_chk++;
            if (beat_cyc[63] - beat_cyc[0] != 63) begin
                n_fail++;
                $display("FAIL good_throughput: got span %0d want 63",
                         beat_cyc[63] - beat_cyc[0]);
            end
        end
        lat = first_valid - empty_fall;
        n_chk++;
        if (empty_fall < 0 || first_valid < 0 || lat < 0 || lat > 5) begin
            n_fail++;
            $display("FAIL good_latency: got %0d cycles want <=5", lat);
        end
        n_chk++;
        if (frame_cnt !== 16'(STATS ? exp_good : 0)) begin
            n_fail++;
            $display("FAIL good_frame_cnt: got %0d want %0d", frame_cnt,
                     STATS ? exp_good : 0);
        end
    endtask

    task automatic test_crc_drop();
        logic [9:0] e;
        clear_obs();
        push_frame(16'h8040, 64, 8'h40);
        tick(120);
        exp_crc++;
        n_chk++;
        if (beats.size() != 0) begin
            n_fail++;
            $display("FAIL crc_no_beats: got %0d beats want 0", beats.size());
        end
        n_chk++;
        if (data_pops != 64) begin
            n_fail++;
            $display("FAIL crc_pops: got %0d want 64", data_pops);
        end
        n_chk++;
        if (crc_err_cnt !== 16'(STATS ? exp_crc : 0)) begin
            n_fail++;
            $display("FAIL crc_cnt: got %0d want %0d", crc_err_cnt, STATS ? exp_crc : 0);
        end
        clear_obs();
        push_frame(16'h0040, 64, 8'h80);
        tick(120);
        exp_good++;
        n_chk++;
        if (beats.size() != 64) begin
            n_fail++;
            $display("FAIL crc_next_count: got %0d beats want 64", beats.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                e = {i == 0, i == 63, 8'h80 + 8'(i)};
                n_chk++;
                if (beats[i] !== e) begin
                    n_fail++;
                    $display("FAIL crc_next_beat[%0d]: got %h want %h", i, beats[i], e);
                end
            end
        end
        n_chk++;
        if (frame_cnt !== 16'(STATS ? exp_good : 0)) begin
            n_fail++;
            $display("FAIL crc_frame_cnt: got %0d want %0d", frame_cnt,
                     STATS ? exp_good : 0);
        end
    endtask

    task automatic test_ready_toggle();
        logic [9:0] e;
        clear_obs();
        occ_err = 0;
        fwd_chk = 1'b1;
        push_frame(16'h0040, 64, 8'hC0);
        for (int c = 0; c < 300; c++) begin
            rx_ready = ~rx_ready;
            tick(1);
        end
        rx_ready = 1'b1;
        tick(10);
        fwd_chk = 1'b0;
        exp_good++;
        n_chk++;
        if (beats.size() != 64) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d beats want 64", beats.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                e = {i == 0, i == 63, 8'hC0 + 8'(i)};
                n_chk++;
                if (beats[i] !== e) begin
                    n_fail++;
                    $display("FAIL toggle_beat[%0d]: got %h want %h", i, beats[i], e);
                end
            end
        end
        n_chk++;
        if (occ_err != 0) begin
            n_fail++;
            $display("FAIL toggle_skid_level: got %0d overfull pops want 0", occ_err);
        end
        n_chk++;
        if (stall_err != 0) begin
            n_fail++;
            $display("FAIL toggle_stable: got %0d unstable stalls want 0", stall_err);
        end
    endtask

    task automatic test_len_edges();
        clear_obs();
        push_frame(16'h0001, 1, 8'h5A);
        tick(30);
        exp_good++;
        n_chk++;
        if (beats.size() != 1 || beats[0] !== 10'h35A) begin
            n_fail++;
            $display("FAIL len_one: got %0d beats first %h want 1 beat 35a",
                     beats.size(), (beats.size() > 0) ? beats[0] : 10'h0);
        end
        clear_obs();
        push_frame(16'h0640, 1600, 8'h00);
        tick(1700);
        exp_len++;
        n_chk++;
        if (beats.size() != 0 || data_pops != 1600) begin
            n_fail++;
            $display("FAIL len_1600: got %0d beats %0d pops want 0 beats 1600 pops",
                     beats.size(), data_pops);
        end
        n_chk++;
        if (len_err_cnt !== 16'(STATS ? exp_len : 0)) begin
            n_fail++;
            $display("FAIL len_1600_cnt: got %0d want %0d", len_err_cnt,
                     STATS ? exp_len : 0);
        end
        clear_obs();
        push_frame(16'h05EF, 1519, 8'h11);
        tick(1600);
        exp_len++;
        n_chk++;
        if (beats.size() != 0 || data_pops != 1519 || dat_q.size() != 0) begin
            n_fail++;
            $display("FAIL len_1519: got %0d beats %0d pops %0d left want 0/1519/0",
                     beats.size(), data_pops, dat_q.size());
        end
        clear_obs();
        push_frame(16'h0000, 0, 8'h00);
        tick(20);
        exp_len++;
        n_chk++;
        if (data_pops != 0 || ptr_pops != 1) begin
            n_fail++;
            $display("FAIL len_zero: got %0d data pops %0d ptr pops want 0/1",
                     data_pops, ptr_pops);
        end
        n_chk++;
        if (len_err_cnt !== 16'(STATS ? exp_len : 0)) begin
            n_fail++;
            $display("FAIL len_zero_cnt: got %0d want %0d", len_err_cnt,
                     STATS ? exp_len : 0);
        end
        clear_obs();
        push_frame(16'hC010, 16, 8'h20);
        tick(40);
        exp_crc++;
        n_chk++;
        if (crc_err_cnt !== 16'(STATS ? exp_crc : 0) ||
            len_err_cnt !== 16'(STATS ? exp_len : 0) || data_pops != 16) begin
            n_fail++;
            $display("FAIL both_bits: got crc %0d len %0d pops %0d want %0d/%0d/16",
                     crc_err_cnt, len_err_cnt, data_pops,
                     STATS ? exp_crc : 0, STATS ? exp_len : 0);
        end
        n_chk++;
        if (frame_cnt !== 16'(STATS ? exp_good : 0)) begin
            n_fail++;
            $display("FAIL len_frame_cnt: got %0d want %0d", frame_cnt,
                     STATS ? exp_good : 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        bit hit;
        clear_obs();
        push_frame(16'h0040, 64, 8'h00);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            tick(1);
            if (beats.size() >= 30) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL mid_wait: got %0d beats want 30 within 200 cycles", beats.size());
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({rx_valid, rx_sof, rx_eof, rx_data, ptr_fifo_rd, data_fifo_rd} !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_rst_outputs: got %h want 0",
                     {rx_valid, rx_sof, rx_eof, rx_data, ptr_fifo_rd, data_fifo_rd});
        end
        n_chk++;
        if ({frame_cnt, crc_err_cnt, len_err_cnt} !== 48'd0) begin
            n_fail++;
            $display("FAIL mid_rst_counters: got %h want 0",
                     {frame_cnt, crc_err_cnt, len_err_cnt});
        end
        tick(2);
        rst = 1'b0;
        exp_good = 0;
        exp_crc = 0;
        exp_len = 0;
        tick(2);
        clear_obs();
        push_frame(16'h0040, 64, 8'h10);
        tick(120);
        exp_good++;
        n_chk++;
        if (beats.size() != 64) begin
            n_fail++;
            $display("FAIL mid_next_count: got %0d beats want 64", beats.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                e = {i == 0, i == 63, 8'h10 + 8'(i)};
                n_chk++;
                if (beats[i] !== e) begin
                    n_fail++;
                    $display("FAIL mid_next_beat[%0d]: got %h want %h", i, beats[i], e);
                end
            end
        end
        n_chk++;
        if (frame_cnt !== 16'(STATS ? exp_good : 0)) begin
            n_fail++;
            $display("FAIL mid_frame_cnt: got %0d want %0d", frame_cnt,
                     STATS ? exp_good : 0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_drop();
        test_ready_toggle();
        test_len_edges();
        test_reset_mid();
        n_chk++;
        if (underflow != 0) begin
            n_fail++;
            $display("FAIL fifo_underflow: got %0d empty pops want 0", underflow);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
